servo_ramp_ctrl: RTL and testbench
==================================

Name: servo_ramp_ctrl

Overview:
- Upstream command stage for pwm_driver.
- Accepts a target servo pulse width (PWM ticks) over a valid/ready handshake and clamps it to the legal range.
- Slews the width it drives onto pwm_driver's data input by at most STEP ticks per PWM frame, so the servo never jumps.
- After reaching the target, holds for a settle dwell, then pulses done and re-opens ready.

Parameters:
- MIN_WIDTH, 50: lowest legal pulse width, in PWM ticks.
- MAX_WIDTH, 250: highest legal pulse width, in PWM ticks.
- STEP, 4: maximum change of o_data per frame, in ticks; must be ≥ 1.
- FRAME_CYCLES, 2001000: i_clk cycles per PWM frame (divider 1000 × 2001 counts).
- SETTLE_FRAMES, 10: frames to dwell at the target before done; 0 is allowed.

Ports:
- i_clk, input, 1: system clock, the same clock that feeds pwm_driver.
- i_rst, input, 1: synchronous reset, active-high.
- i_target, input, 13: requested pulse width, unclamped.
- i_valid, input, 1: i_target is valid.
- o_ready, output, 1: block can accept a new target.
- i_abort, input, 1: freeze at the current width and return to IDLE.
- o_data, output, 13: pulse width to pwm_driver.data.
- o_busy, output, 1: high in RAMP or SETTLE.
- o_done, output, 1: one-cycle pulse when the settle dwell completes.
- o_clamped, output, 1: registered flag; the last accepted target was out of range.

Behaviour:
- Reset (i_rst high at a posedge):
  - o_data = MIN_WIDTH, state = IDLE, o_ready = 1, o_busy = 0, o_done = 0, o_clamped = 0.
  - Frame counter = 0, settle counter = 0.
  - Reset mid-ramp discards the target; o_data returns to MIN_WIDTH on the next cycle.
- Frame tick:
  - The counter runs 0..FRAME_CYCLES-1 continuously, in every state.
  - frame_tick is high for one cycle when the counter equals FRAME_CYCLES-1, after which the counter wraps to 0.
  - The counter is free-running. It is not restarted on target acceptance, so the first step occurs 1..FRAME_CYCLES cycles after acceptance.
- Handshake:
  - Transfer happens when i_valid && o_ready at a posedge.
  - o_ready = (state == IDLE).
  - i_valid while not ready is ignored; there is no queue.
- Clamping on accept:
  - tgt_q = MIN_WIDTH if i_target < MIN_WIDTH; MAX_WIDTH if i_target > MAX_WIDTH; otherwise i_target.
  - o_clamped = 1 if clamping occurred, else 0. It holds until the next accept or reset.
- State IDLE:
  - On transfer, go to RAMP.
  - If tgt_q equals o_data, RAMP finishes on the first frame_tick with no change to o_data.
- State RAMP: on each frame_tick:
  - If |tgt_q − o_data| ≤ STEP: o_data = tgt_q, load the settle counter with SETTLE_FRAMES, go to SETTLE.
  - Else if tgt_q > o_data: o_data += STEP.
  - Else: o_data −= STEP.
  - Compute the difference unsigned, larger minus smaller, to avoid wrap.
- State SETTLE:
  - If the counter is 0, pulse o_done on the same cycle as the transition and go to IDLE. With SETTLE_FRAMES = 0 this happens on the cycle after entering SETTLE.
  - Otherwise, on each frame_tick, decrement the counter; when it reaches 0, pulse o_done for one cycle and go to IDLE.
- Abort:
  - i_abort in RAMP or SETTLE: go to IDLE next cycle; o_data holds its current value; no o_done.
  - i_abort in IDLE has no effect.
  - When i_abort and a transfer coincide, abort wins and the target is not accepted. While in IDLE, o_ready must be gated with !i_abort.
- o_data changes only on frame_tick, on reset, or never (abort). It therefore stays constant within a PWM frame.
- Outputs are registered. o_busy = (state != IDLE).

Decomposition:
- Package servo_pkg holds:
  - state enum IDLE, RAMP, SETTLE;
  - WIDTH_W = 13;
  - default MIN_WIDTH and MAX_WIDTH constants, shared with pwm_driver-side code.
- Sub-module frame_tick_gen (parameter FRAME_CYCLES; ports i_clk, i_rst, o_tick) holds the free-running frame counter.
- The FSM, clamp and slew logic stay in servo_ramp_ctrl.

Test Plan (bench overrides FRAME_CYCLES=10, SETTLE_FRAMES=2, STEP=4):
1. Reset, then hold idle for 50 cycles -> o_data=50, o_ready=1, o_busy=0, o_done never asserted.
2. Accept 70 from reset -> o_data steps 54, 58, …, 70 on consecutive ticks (5 ticks), then o_done pulses exactly 2 ticks later, then o_ready=1.
3. Accept 300, then accept 10 -> first ramps to 250 with o_clamped=1; second ramps down to 50 with o_clamped=1. Accept 52 from 50 -> o_data=52 on the first tick (residual ≤ STEP), o_clamped=0.
4. i_valid=1 with 200 during RAMP toward 100 -> ignored; o_data ends at 100; one o_done pulse only.
5. i_abort mid-ramp at o_data=62 -> next cycle IDLE, o_data holds 62, no o_done. Abort coincident with i_valid in IDLE -> o_ready=0 that cycle, no transfer.
6. i_rst asserted at o_data=150 mid-SETTLE -> next cycle o_data=50, state IDLE, o_done=0. Also accept target equal to o_data -> o_data unchanged, o_done after 1+2 ticks.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared types and constants for the servo command path and pwm_driver-side code.
package servo_pkg;

  localparam int unsigned WIDTH_W       = 13;
  localparam int unsigned DEF_MIN_WIDTH = 50;
  localparam int unsigned DEF_MAX_WIDTH = 250;

  typedef logic [WIDTH_W-1:0] width_t;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SETTLE
  } state_e;

  typedef struct packed {
    width_t tgt;
    logic   clamped;
  } cmd_t;

  function automatic cmd_t clamp_target(input width_t t, input width_t lo, input width_t hi);
    cmd_t c;
    c.tgt     = t;
    c.clamped = 1'b0;
    if (t < lo) begin
      c.tgt     = lo;
      c.clamped = 1'b1;
    end else if (t > hi) begin
      c.tgt     = hi;
      c.clamped = 1'b1;
    end
    return c;
  endfunction

  // Larger minus smaller, so the distance never wraps.
  function automatic width_t abs_diff(input width_t a, input width_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running PWM frame counter; o_tick marks the last cycle of each frame.
module frame_tick_gen #(
  parameter int unsigned FRAME_CYCLES = 2001000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int unsigned CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (o_tick) cnt_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Accepts a clamped servo target and slews the pwm_driver width toward it one
// bounded step per frame, then dwells before signalling done.
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned MIN_WIDTH     = DEF_MIN_WIDTH,
  parameter int unsigned MAX_WIDTH     = DEF_MAX_WIDTH,
  parameter int unsigned STEP          = 4,
  parameter int unsigned FRAME_CYCLES  = 2001000,
  parameter int unsigned SETTLE_FRAMES = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [WIDTH_W-1:0] i_target,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_abort,
  output logic [WIDTH_W-1:0] o_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_clamped
);

  localparam int unsigned SW = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam width_t        MIN_W       = WIDTH_W'(MIN_WIDTH);
  localparam width_t        MAX_W       = WIDTH_W'(MAX_WIDTH);
  localparam width_t        STEP_W      = WIDTH_W'(STEP);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_FRAMES);

  state_e        state_q, state_d;
  width_t        data_q, data_d;
  width_t        tgt_q, tgt_d;
  logic          clamped_q, clamped_d;
  logic          done_q, done_d;
  logic [SW-1:0] settle_q, settle_d;

  logic   tick;
  logic   accept;
  cmd_t   cmd;
  width_t diff;

  frame_tick_gen #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_tick(tick)
  );

  // Abort beats a coincident transfer, so ready drops combinationally with it.
  assign o_ready = (state_q == IDLE) && !i_abort;
  assign accept  = i_valid && o_ready;
  assign cmd     = clamp_target(i_target, MIN_W, MAX_W);
  assign diff    = abs_diff(tgt_q, data_q);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    tgt_d     = tgt_q;
    clamped_d = clamped_q;
    done_d    = 1'b0;
    settle_d  = settle_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d     = cmd.tgt;
          clamped_d = cmd.clamped;
          state_d   = RAMP;
        end
      end
      RAMP: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (tick) begin
          if (diff <= STEP_W) begin
            data_d   = tgt_q;
            settle_d = SETTLE_INIT;
            state_d  = SETTLE;
          end else if (tgt_q > data_q) begin
            data_d = data_q + STEP_W;
          end else begin
            data_d = data_q - STEP_W;
          end
        end
      end
      SETTLE: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (settle_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tick) begin
          settle_d = settle_q - 1'b1;
          if (settle_q == SW'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      data_q    <= MIN_W;
      tgt_q     <= MIN_W;
      clamped_q <= 1'b0;
      done_q    <= 1'b0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      tgt_q     <= tgt_d;
      clamped_q <= clamped_d;
      done_q    <= done_d;
      settle_q  <= settle_d;
    end
  end

  assign o_data    = data_q;
  assign o_busy    = (state_q != IDLE);
  assign o_done    = done_q;
  assign o_clamped = clamped_q;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed plus randomized checks of servo_ramp_ctrl against a per-transaction trajectory model.
module tb_servo_ramp_ctrl;

  localparam int FC   = 10;
  localparam int SF   = 2;
  localparam int ST   = 4;
  localparam int MINW = 50;
  localparam int MAXW = 250;

  logic        i_clk    = 1'b0;
  logic        i_rst    = 1'b1;
  logic        i_valid  = 1'b0;
  logic        i_abort  = 1'b0;
  logic [12:0] i_target = '0;
  logic        o_ready, o_busy, o_done, o_clamped;
  logic [12:0] o_data;

  int vecs  = 0;
  int fails = 0;
  int fcnt  = 0;
  bit was_tick = 1'b0;
  int m_data   = MINW;
  int m_clamped = 0;

  servo_ramp_ctrl #(
    .MIN_WIDTH    (MINW),
    .MAX_WIDTH    (MAXW),
    .STEP         (ST),
    .FRAME_CYCLES (FC),
    .SETTLE_FRAMES(SF)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_target (i_target),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_abort  (i_abort),
    .o_data   (o_data),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_clamped(o_clamped)
  );

  always #5 i_clk = ~i_clk;

  // Frame timing as stated: free-running 0..FC-1, tick on the last count.
  always @(posedge i_clk) begin
    was_tick = !i_rst && (fcnt == FC - 1);
    fcnt     = (i_rst || was_tick) ? 0 : fcnt + 1;
  end

  task automatic cyc();
    @(negedge i_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".data"},    o_data,    m_data);
    chk({tag, ".ready"},   o_ready,   1);
    chk({tag, ".busy"},    o_busy,    0);
    chk({tag, ".done"},    o_done,    0);
    chk({tag, ".clamped"}, o_clamped, m_clamped);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_abort = 1'b0;
    cyc();
    m_data = MINW; m_clamped = 0;
    chk_idle("reset");
    i_rst = 1'b0;
  endtask

  // kill_at: 0 none, >0 kill after that many ticks, -1 random point before done.
  task automatic run(input int target, input int junk, input int kill_at, input bit kill_rst);
    int ct, x, n, ticks, budget, kat;
    int traj[$];
    bit fin;
    ct = (target < MINW) ? MINW : ((target > MAXW) ? MAXW : target);
    x  = m_data;
    while (((ct > x) ? ct - x : x - ct) > ST) begin
      x = (ct > x) ? x + ST : x - ST;
      traj.push_back(x);
    end
    traj.push_back(ct);
    n   = traj.size();
    kat = (kill_at < 0) ? int'($urandom_range(n + SF - 1, 1)) : kill_at;

    i_target = target[12:0]; i_valid = 1'b1;
    cyc();
    m_clamped = (ct != target) ? 1 : 0;
    chk("acc.busy",    o_busy,    1);
    chk("acc.clamped", o_clamped, m_clamped);
    chk("acc.data",    o_data,    m_data);

    ticks = 0; fin = 1'b0; budget = (n + SF + 2) * FC;
    for (int c = 1; c <= budget && !fin; c++) begin
      if (c <= junk) begin i_valid = 1'b1; i_target = 13'd200; end
      else i_valid = 1'b0;
      if (kat > 0 && ticks == kat) begin
        if (kill_rst) i_rst = 1'b1; else i_abort = 1'b1;
      end
      cyc();
      if (i_rst) begin
        i_rst = 1'b0; fin = 1'b1;
        m_data = MINW; m_clamped = 0;
        chk("rst.data",    o_data,    MINW);
        chk("rst.busy",    o_busy,    0);
        chk("rst.done",    o_done,    0);
        chk("rst.clamped", o_clamped, 0);
      end else if (i_abort) begin
        i_abort = 1'b0; fin = 1'b1;
        chk("abort.data", o_data, m_data);
        chk("abort.busy", o_busy, 0);
        chk("abort.done", o_done, 0);
      end else begin
        if (was_tick) begin
          ticks++;
          if (traj.size() > 0) m_data = traj.pop_front();
        end
        chk("ramp.data", o_data, m_data);
        if (was_tick && ticks == n + SF) begin
          fin = 1'b1;
          chk("done.pulse", o_done,  1);
          chk("done.ready", o_ready, 1);
          chk("done.busy",  o_busy,  0);
        end else begin
          chk("ramp.nodone", o_done,  0);
          chk("ramp.busy",   o_busy,  1);
          chk("ramp.ready",  o_ready, 0);
        end
      end
    end
    i_valid = 1'b0;
    if (!fin) chk("timeout", fin, 1);
    cyc();
    chk_idle("after");
  endtask

  initial begin
    // 1: reset and idle
    do_reset();
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk_idle("idle");
    end
    // 2: small ramp up, 54..70 then 2-frame dwell
    run(70, 0, 0, 0);
    // 3: clamping both ends, then residual step smaller than STEP
    run(300, 0, 0, 0);
    run(10, 0, 0, 0);
    run(52, 0, 0, 0);
    // 4: valid during ramp is ignored
    run(100, 20, 0, 0);
    // 5: abort at 62, then abort coincident with valid in IDLE
    run(50, 0, 0, 0);
    run(100, 0, 3, 0);
    chk("abort62.data", o_data, 62);
    i_abort = 1'b1; i_valid = 1'b1; i_target = 13'd120;
    #1;
    chk("abort_idle.ready", o_ready, 0);
    cyc();
    i_abort = 1'b0; i_valid = 1'b0;
    chk("abort_idle.busy", o_busy, 0);
    chk("abort_idle.data", o_data, m_data);
    cyc();
    chk_idle("abort_idle");
    // 6: reset mid-SETTLE at 150 (62->150 is 22 ticks), then target equal to o_data
    run(150, 0, 23, 1);
    run(50, 0, 0, 0);
    // randomized targets with occasional aborts
    for (int k = 0; k < 10; k++) begin
      int t;
      t = int'($urandom_range(400, 0));
      run(t, 0, ($urandom_range(2, 0) == 0) ? -1 : 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
